// File: rtl/mmio_controller.sv
// mmio_controller
// Memory-mapped I/O stage that sits beside data memory. It decodes the
// 0xF00000xx window, holds the HEX/LEDR/LEDG output registers, synchronizes
// the switches, and synchronizes and debounces the keys. It returns load data
// to the register-file write mux and raises isIo so the top level can steer
// dOut and block data-memory writes.
// Optional feature: define MMIO_KEY_EDGE_EN to add sticky key-press flags
// at ADDR_KEYEDGE. These flags are write-1-to-clear, and a new press wins
// over a clear that lands on the same edge.
module mmio_controller #(
    parameter int unsigned      DBITS           = 32,
    parameter logic [DBITS-1:0] ADDR_HEX        = 32'hF0000000,
    parameter logic [DBITS-1:0] ADDR_LEDR       = 32'hF0000004,
    parameter logic [DBITS-1:0] ADDR_LEDG       = 32'hF0000008,
    parameter logic [DBITS-1:0] ADDR_KEY        = 32'hF0000010,
    parameter logic [DBITS-1:0] ADDR_SW         = 32'hF0000014,
    parameter logic [DBITS-1:0] ADDR_KEYEDGE    = 32'hF0000018,
    parameter logic [15:0]      DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] addr,
    input  logic             wrtEn,
    input  logic [DBITS-1:0] dIn,
    output logic [DBITS-1:0] dOut,
    output logic             isIo,
    input  logic [9:0]       SW,
    input  logic [3:0]       KEY,
    output logic [9:0]       LEDR,
    output logic [7:0]       LEDG,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX2,
    output logic [6:0]       HEX3
);

    // The stable level flips on the edge where the counter already holds
    // this value. That edge is the DEBOUNCE_CYCLES-th consecutive disagreeing
    // sample.
    localparam logic [15:0] DEB_LAST = DEBOUNCE_CYCLES - 16'd1;
    localparam logic [15:0] CNT_MAX  = 16'hFFFF;

    // Output registers
    logic [15:0] hex_q,  hex_d;
    logic [9:0]  ledr_q, ledr_d;
    logic [7:0]  ledg_q, ledg_d;

    // Switch synchronizer
    logic [9:0]  sw_sync1_q, sw_sync2_q;

    // Key synchronizer. The raw keys are active-low, so both flops reset
    // to "released".
    logic [3:0]  key_sync1_q, key_sync2_q;
    logic [3:0]  key_pressed;

    // Debounce state
    logic [3:0]  key_stable_q, key_stable_d;
    logic [15:0] key_cnt_q [4];
    logic [15:0] key_cnt_d [4];

    // Write strobes
    logic        wr_hex, wr_ledr, wr_ledg;

    // Only the low 16 bits of store data ever land in a register
    logic        unused_din_hi;
    assign unused_din_hi = ^dIn[DBITS-1:16];

    // Active-low 7-segment patterns for one hex digit
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    assign isIo = (addr[DBITS-1 -: 4] == 4'hF);

    // Register address decode. An exact full-width match is required, so
    // non-I/O addresses and unmapped I/O offsets never hit a register.
    always_comb begin
        wr_hex  = wrtEn && (addr == ADDR_HEX);
        wr_ledr = wrtEn && (addr == ADDR_LEDR);
        wr_ledg = wrtEn && (addr == ADDR_LEDG);
    end

    // Next value of the writable output registers
    always_comb begin
        hex_d  = hex_q;
        ledr_d = ledr_q;
        ledg_d = ledg_q;
        if (wr_hex) begin
            hex_d = dIn[15:0];
        end
        if (wr_ledr) begin
            ledr_d = dIn[9:0];
        end
        if (wr_ledg) begin
            ledg_d = dIn[7:0];
        end
    end

    // Output registers, cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            hex_q  <= '0;
            ledr_q <= '0;
            ledg_q <= '0;
        end else begin
            hex_q  <= hex_d;
            ledr_q <= ledr_d;
            ledg_q <= ledg_d;
        end
    end

    // Two-flop synchronizers for the asynchronous board inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_sync1_q  <= '0;
            sw_sync2_q  <= '0;
            key_sync1_q <= 4'hF;
            key_sync2_q <= 4'hF;
        end else begin
            sw_sync1_q  <= SW;
            sw_sync2_q  <= sw_sync1_q;
            key_sync1_q <= KEY;
            key_sync2_q <= key_sync1_q;
        end
    end

    assign key_pressed = ~key_sync2_q;

    // Per-key debounce. A key that agrees with its stable level clears its
    // counter. A key that disagrees counts up and is accepted once it has
    // disagreed for DEBOUNCE_CYCLES samples in a row. The counter saturates
    // instead of wrapping.
    always_comb begin
        key_stable_d = key_stable_q;
        for (int i = 0; i < 4; i++) begin
            key_cnt_d[i] = key_cnt_q[i];
            if (key_pressed[i] == key_stable_q[i]) begin
                key_cnt_d[i] = '0;
            end else if (key_cnt_q[i] == DEB_LAST) begin
                key_stable_d[i] = key_pressed[i];
                key_cnt_d[i]    = '0;
            end else if (key_cnt_q[i] != CNT_MAX) begin
                key_cnt_d[i] = key_cnt_q[i] + 16'd1;
            end
        end
    end

    // Debounce state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            key_stable_q <= '0;
            for (int i = 0; i < 4; i++) begin
                key_cnt_q[i] <= '0;
            end
        end else begin
            key_stable_q <= key_stable_d;
            for (int i = 0; i < 4; i++) begin
                key_cnt_q[i] <= key_cnt_d[i];
            end
        end
    end

`ifdef MMIO_KEY_EDGE_EN
    logic [3:0] key_edge_q, key_edge_d;
    logic       wr_keyedge;

    assign wr_keyedge = wrtEn && (addr == ADDR_KEYEDGE);

    // Sticky press flags. The clear is applied first so that a press arriving
    // on the same edge survives.
    always_comb begin
        key_edge_d = key_edge_q;
        if (wr_keyedge) begin
            key_edge_d = key_edge_d & ~dIn[3:0];
        end
        key_edge_d = key_edge_d | (key_stable_d & ~key_stable_q);
    end

    // Press flag register
    always_ff @(posedge clk) begin
        if (reset) begin
            key_edge_q <= '0;
        end else begin
            key_edge_q <= key_edge_d;
        end
    end
`endif

    // Load data mux. It is zero-extended and has no read side effects.
    // Anything that is not a register reads as zero.
    always_comb begin
        dOut = '0;
        case (addr)
            ADDR_HEX:     dOut = {{(DBITS-16){1'b0}}, hex_q};
            ADDR_LEDR:    dOut = {{(DBITS-10){1'b0}}, ledr_q};
            ADDR_LEDG:    dOut = {{(DBITS-8){1'b0}},  ledg_q};
            ADDR_KEY:     dOut = {{(DBITS-4){1'b0}},  key_stable_q};
            ADDR_SW:      dOut = {{(DBITS-10){1'b0}}, sw_sync2_q};
`ifdef MMIO_KEY_EDGE_EN
            ADDR_KEYEDGE: dOut = {{(DBITS-4){1'b0}},  key_edge_q};
`else
            ADDR_KEYEDGE: dOut = '0;
`endif
            default:      dOut = '0;
        endcase
    end

    assign LEDR = ledr_q;
    assign LEDG = ledg_q;
    assign HEX0 = hex_to_seg(hex_q[3:0]);
    assign HEX1 = hex_to_seg(hex_q[7:4]);
    assign HEX2 = hex_to_seg(hex_q[11:8]);
    assign HEX3 = hex_to_seg(hex_q[15:12]);

endmodule

// File: tb/tb_mmio_controller.sv
// Bench for mmio_controller: directed steps followed by randomized bus and
// board traffic. Expected values come from a behavioural model that tracks
// the register contents, the two-cycle input delay, and the rule that a key
// level is accepted after DEB consecutive agreeing samples.
module tb_mmio_controller;

    localparam int DEB = 8;
    localparam logic [31:0] A_HEX     = 32'hF0000000;
    localparam logic [31:0] A_LEDR    = 32'hF0000004;
    localparam logic [31:0] A_LEDG    = 32'hF0000008;
    localparam logic [31:0] A_KEY     = 32'hF0000010;
    localparam logic [31:0] A_SW      = 32'hF0000014;
    localparam logic [31:0] A_KEYEDGE = 32'hF0000018;
    localparam logic [6:0] SEG [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, dIn, dOut;
    logic        wrtEn, isIo;
    logic [9:0]  SW, LEDR;
    logic [3:0]  KEY;
    logic [7:0]  LEDG;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3;

    int compared   = 0;
    int mismatched = 0;

    // Model state
    logic [15:0] m_hex;
    logic [9:0]  m_ledr;
    logic [7:0]  m_ledg;
    logic [3:0]  m_stable;
    logic [3:0]  m_edge;
    logic [9:0]  sw_hist[$];
    logic [3:0]  pressed_hist[$];
    logic [3:0]  synced_hist[$];

    logic [31:0] addr_pool [8] = '{A_HEX, A_LEDR, A_LEDG, A_KEY, A_SW, A_KEYEDGE,
                                   32'hF000000C, 32'h00000100};

    mmio_controller #(.DEBOUNCE_CYCLES(16'd8)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wrtEn(wrtEn), .dIn(dIn),
        .dOut(dOut), .isIo(isIo), .SW(SW), .KEY(KEY), .LEDR(LEDR), .LEDG(LEDG),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3)
    );

    always #5 clk = ~clk;

    // Advance the model by one clock edge, using the inputs presented to it
    function automatic void model_step();
        logic [3:0] synced, new_stable, clr;
        bit         held;
        if (reset) begin
            m_hex = '0; m_ledr = '0; m_ledg = '0; m_stable = '0; m_edge = '0;
            sw_hist = {10'h0, 10'h0};
            pressed_hist = {4'h0, 4'h0};
            synced_hist = {};
            for (int k = 0; k < DEB; k++) synced_hist.push_back(4'h0);
            return;
        end
        clr = 4'h0;
        if (wrtEn) begin
            if (addr == A_HEX)     m_hex  = dIn[15:0];
            if (addr == A_LEDR)    m_ledr = dIn[9:0];
            if (addr == A_LEDG)    m_ledg = dIn[7:0];
            if (addr == A_KEYEDGE) clr    = dIn[3:0];
        end
        // A key sampled at edge n is seen by the debouncer at edge n+2
        synced = pressed_hist[pressed_hist.size()-2];
        synced_hist.push_back(synced);
        new_stable = m_stable;
        for (int i = 0; i < 4; i++) begin
            held = 1'b1;
            for (int k = 1; k <= DEB; k++)
                if (synced_hist[synced_hist.size()-k][i] == m_stable[i]) held = 1'b0;
            if (held) new_stable[i] = ~m_stable[i];
        end
        m_edge   = (m_edge & ~clr) | (new_stable & ~m_stable);
        m_stable = new_stable;
        pressed_hist.push_back(~KEY);
        sw_hist.push_back(SW);
        while (pressed_hist.size() > 4) void'(pressed_hist.pop_front());
        while (sw_hist.size() > 4) void'(sw_hist.pop_front());
        while (synced_hist.size() > DEB + 2) void'(synced_hist.pop_front());
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        case (a)
            A_HEX:     return {16'h0, m_hex};
            A_LEDR:    return {22'h0, m_ledr};
            A_LEDG:    return {24'h0, m_ledg};
            A_KEY:     return {28'h0, m_stable};
            A_SW:      return {22'h0, sw_hist[sw_hist.size()-2]};
`ifdef MMIO_KEY_EDGE_EN
            A_KEYEDGE: return {28'h0, m_edge};
`endif
            default:   return 32'h0;
        endcase
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 32'h%08h expected 32'h%08h", tag, obs, exp);
        end
    endtask

    task automatic check_read(input string tag, input logic [31:0] a);
        addr = a;
        wrtEn = 1'b0;
        #1;
        check_output(tag, dOut, model_read(a));
    endtask

    task automatic check_leds(input string tag);
        check_output({tag, "_ledr"}, {22'h0, LEDR}, {22'h0, m_ledr});
        check_output({tag, "_ledg"}, {24'h0, LEDG}, {24'h0, m_ledg});
        check_output({tag, "_hex0"}, {25'h0, HEX0}, {25'h0, SEG[m_hex[3:0]]});
        check_output({tag, "_hex1"}, {25'h0, HEX1}, {25'h0, SEG[m_hex[7:4]]});
        check_output({tag, "_hex2"}, {25'h0, HEX2}, {25'h0, SEG[m_hex[11:8]]});
        check_output({tag, "_hex3"}, {25'h0, HEX3}, {25'h0, SEG[m_hex[15:12]]});
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr = a;
        dIn = d;
        wrtEn = 1'b1;
        tick();
        wrtEn = 1'b0;
    endtask

    initial begin
        int hold;
        reset = 1'b1; wrtEn = 1'b0; addr = '0; dIn = '0; SW = '0; KEY = 4'hF;

        // Step 1: reset held for three cycles
        repeat (3) tick();
        reset = 1'b0;
        check_output("rst_hex0", {25'h0, HEX0}, {25'h0, 7'b1000000});
        check_output("rst_hex3", {25'h0, HEX3}, {25'h0, 7'b1000000});
        check_output("rst_ledr", {22'h0, LEDR}, 32'h0);
        check_leds("rst");
        for (int i = 0; i < 8; i++) begin
            check_read("rst_rd", addr_pool[i]);
            check_output("rst_rd0", dOut, 32'h0);
        end

        // Step 2: HEX and LEDR writes
        bus_write(A_HEX, 32'h0000BEEF);
        check_output("hex3_b", {25'h0, HEX3}, {25'h0, 7'b0000011});
        check_output("hex0_f", {25'h0, HEX0}, {25'h0, 7'b0001110});
        bus_write(A_LEDR, 32'hFFFFFFFF);
        check_output("ledr_all", {22'h0, LEDR}, 32'h3FF);
        check_leds("wr");
        check_read("rd_hex", A_HEX);
        check_output("rd_hex_c", dOut, 32'hBEEF);
        check_read("rd_ledr", A_LEDR);
        check_output("rd_ledr_c", dOut, 32'h3FF);

        // Step 3: switches reach dOut two cycles after changing
        SW = 10'h2A5;
        tick();
        check_read("sw_1cyc", A_SW);
        check_output("sw_1cyc_c", dOut, 32'h0);
        tick();
        check_read("sw_2cyc", A_SW);
        check_output("sw_2cyc_c", dOut, 32'h2A5);
        bus_write(A_SW, 32'h0);
        check_read("sw_ro", A_SW);
        check_output("sw_ro_c", dOut, 32'h2A5);

        // Step 4: short glitch on KEY[1] is rejected, a held press is accepted
        KEY = 4'b1101;
        repeat (5) tick();
        KEY = 4'hF;
        for (int i = 0; i < 12; i++) begin
            tick();
            check_read("key_glitch", A_KEY);
        end
        check_output("key_glitch_c", dOut, 32'h0);
        KEY = 4'b1101;
        repeat (DEB + 1) tick();
        check_read("key_early", A_KEY);
        check_output("key_early_c", dOut, 32'h0);
        tick();
        check_read("key_press", A_KEY);
        check_output("key_press_c", dOut, 32'h2);
        KEY = 4'hF;
        repeat (DEB + 4) tick();
        check_read("key_rel", A_KEY);
        check_output("key_rel_c", dOut, 32'h0);

        // Step 5: isIo decode, and a store outside the window
        addr = A_LEDR; #1;
        check_output("isio_hi", {31'h0, isIo}, 32'h1);
        addr = 32'h00000100; #1;
        check_output("isio_lo", {31'h0, isIo}, 32'h0);
        bus_write(32'h00000100, $urandom);
        check_leds("nonio");
        check_read("nonio_hex", A_HEX);
        check_output("nonio_hex_c", dOut, 32'hBEEF);

        // Step 6: sticky key-press flags
        bus_write(A_KEYEDGE, 32'hF);
        check_read("kedge_clr_all", A_KEYEDGE);
        check_output("kedge_clr_all_c", dOut, 32'h0);
`ifdef MMIO_KEY_EDGE_EN
        KEY = 4'b1110;
        repeat (DEB + 2) tick();
        check_read("kedge_set", A_KEYEDGE);
        check_output("kedge_set_c", dOut, 32'h1);
        KEY = 4'hF;
        repeat (DEB + 4) tick();
        check_read("kedge_sticky", A_KEYEDGE);
        check_output("kedge_sticky_c", dOut, 32'h1);
        bus_write(A_KEYEDGE, 32'h1);
        check_read("kedge_w1c", A_KEYEDGE);
        check_output("kedge_w1c_c", dOut, 32'h0);
        KEY = 4'b1110;
        repeat (DEB + 1) tick();
        bus_write(A_KEYEDGE, 32'h1);
        check_read("kedge_setwins", A_KEYEDGE);
        check_output("kedge_setwins_c", dOut, 32'h1);
        KEY = 4'hF;
        repeat (DEB + 4) tick();
`else
        KEY = 4'b1110;
        repeat (DEB + 2) tick();
        check_read("kedge_off", A_KEYEDGE);
        check_output("kedge_off_c", dOut, 32'h0);
        KEY = 4'hF;
        repeat (DEB + 4) tick();
`endif

        // Step 7: randomized bus writes, switch changes and key activity
        hold = 0;
        for (int it = 0; it < 500; it++) begin
            if (hold == 0) begin
                KEY = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
                hold = int'($urandom_range(1, 14));
            end
            hold--;
            if ($urandom_range(0, 7) == 0) SW = 10'($urandom);
            addr = addr_pool[$urandom_range(0, 7)];
            dIn = $urandom;
            wrtEn = ($urandom_range(0, 1) == 1);
            tick();
            check_leds("rnd");
            check_read("rnd_rd", addr_pool[$urandom_range(0, 7)]);
            check_output("rnd_isio", {31'h0, isIo}, {31'h0, addr[31:28] == 4'hF});
        end

        // Reset takes priority over a store on the same edge
        addr = A_LEDR; dIn = 32'h3FF; wrtEn = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0; wrtEn = 1'b0;
        check_output("rst_over_wr", {22'h0, LEDR}, 32'h0);
        check_leds("rst_over");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
